// File: rtl/gtx_oob_ctrl.sv
// ============================================================================
// Module   : gtx_oob_ctrl
// Purpose  : Host-side SATA OOB / link-init sequencer driving GTX COM and idle
//            controls. Optional macro LINK_LOSS_RECOVER_EN adds idle-loss
//            recovery from LINK_UP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gtx_oob_ctrl #(
    parameter logic [31:0] COMINIT_TIMEOUT  = 32'd880000,
    parameter logic [31:0] ALIGN_TIMEOUT    = 32'd65536
`ifdef LINK_LOSS_RECOVER_EN
    ,
    parameter logic [15:0] IDLE_LOSS_CYCLES = 16'd1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_reset_done,
    input  logic        rx_reset_done,
    input  logic        txcomfinish,
    input  logic        rxcominitdet,
    input  logic        rxcomwakedet,
    input  logic        rxelecidle,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_charisk,
    output logic        txcominit,
    output logic        txcomwake,
    output logic        txelecidle,
    output logic        data_valid,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_charisk,
    output logic        link_up,
    output logic [2:0]  oob_state
);

    typedef enum logic [2:0] {
        RESET_WAIT   = 3'd0,
        SEND_COMINIT = 3'd1,
        WAIT_COMINIT = 3'd2,
        SEND_COMWAKE = 3'd3,
        WAIT_COMWAKE = 3'd4,
        WAIT_ALIGN   = 3'd5,
        SEND_SYNC    = 3'd6,
        LINK_UP      = 3'd7
    } state_t;

    localparam logic [31:0] C_D10_2_WORD = 32'h4A4A4A4A;
    localparam logic [31:0] C_ALIGN_WORD = 32'h7B4A4ABC;
    localparam logic [31:0] C_SYNC_WORD  = 32'hB5B5957C;
    localparam logic [3:0]  C_K_BYTE0    = 4'b0001;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;

    logic        txcominit_q, txcominit_d;
    logic        txcomwake_q, txcomwake_d;
    logic        txelecidle_q, txelecidle_d;
    logic        data_valid_q, data_valid_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [3:0]  tx_charisk_q, tx_charisk_d;
    logic        link_up_q, link_up_d;

    logic        resets_ok;
    logic        rx_is_align;
    logic        rx_is_sync;
    logic        link_lost;

    assign resets_ok   = tx_reset_done & rx_reset_done;
    assign rx_is_align = (rx_data == C_ALIGN_WORD) && (rx_charisk == C_K_BYTE0);
    assign rx_is_sync  = (rx_data == C_SYNC_WORD)  && (rx_charisk == C_K_BYTE0);

`ifdef LINK_LOSS_RECOVER_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;

    // Counts consecutive idle cycles only while the link is up.
    always_comb begin
        idle_cnt_d = 16'd0;
        link_lost  = 1'b0;
        if (state_q == LINK_UP && rxelecidle) begin
            if (idle_cnt_q == IDLE_LOSS_CYCLES - 16'd1) begin
                link_lost = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= 16'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_rxelecidle;
    assign unused_rxelecidle = rxelecidle;
    assign link_lost         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_WAIT: begin
                if (resets_ok) state_d = SEND_COMINIT;
            end
            SEND_COMINIT: begin
                if (txcomfinish) state_d = WAIT_COMINIT;
            end
            WAIT_COMINIT: begin
                if (rxcominitdet) begin
                    state_d = SEND_COMWAKE;
                end else if (timer_q == COMINIT_TIMEOUT - 32'd1) begin
                    state_d = SEND_COMINIT;
                end
            end
            SEND_COMWAKE: begin
                if (txcomfinish) state_d = WAIT_COMWAKE;
            end
            WAIT_COMWAKE: begin
                // A device-side COMINIT restarts the wake handshake.
                if (rxcominitdet) begin
                    state_d = SEND_COMWAKE;
                end else if (rxcomwakedet) begin
                    state_d = WAIT_ALIGN;
                end
            end
            WAIT_ALIGN: begin
                if (rx_is_align) begin
                    state_d = SEND_SYNC;
                end else if (timer_q == ALIGN_TIMEOUT - 32'd1) begin
                    state_d = SEND_COMINIT;
                end
            end
            SEND_SYNC: begin
                if (rx_is_sync) begin
                    state_d = LINK_UP;
                end else if (timer_q == ALIGN_TIMEOUT - 32'd1) begin
                    state_d = SEND_COMINIT;
                end
            end
            LINK_UP: begin
                if (link_lost) state_d = SEND_COMINIT;
            end
            default: state_d = RESET_WAIT;
        endcase

        if (state_q != RESET_WAIT && !resets_ok) begin
            state_d = RESET_WAIT;
        end
    end

    // Timer restarts on every state change and only runs in timed states.
    always_comb begin
        timer_d = 32'd0;
        if (state_d == state_q &&
            (state_q == WAIT_COMINIT || state_q == WAIT_ALIGN || state_q == SEND_SYNC)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        txcominit_d  = (state_d == SEND_COMINIT) && (state_q != SEND_COMINIT);
        txcomwake_d  = (state_d == SEND_COMWAKE) && (state_q != SEND_COMWAKE);
        txelecidle_d = 1'b1;
        data_valid_d = 1'b0;
        tx_data_d    = 32'd0;
        tx_charisk_d = 4'd0;
        link_up_d    = 1'b0;
        case (state_d)
            WAIT_ALIGN: begin
                txelecidle_d = 1'b0;
                data_valid_d = 1'b1;
                tx_data_d    = C_D10_2_WORD;
                tx_charisk_d = 4'b0000;
            end
            SEND_SYNC: begin
                txelecidle_d = 1'b0;
                data_valid_d = 1'b1;
                tx_data_d    = C_ALIGN_WORD;
                tx_charisk_d = C_K_BYTE0;
            end
            LINK_UP: begin
                txelecidle_d = 1'b0;
                data_valid_d = 1'b1;
                tx_data_d    = C_SYNC_WORD;
                tx_charisk_d = C_K_BYTE0;
                link_up_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_WAIT;
            timer_q      <= 32'd0;
            txcominit_q  <= 1'b0;
            txcomwake_q  <= 1'b0;
            txelecidle_q <= 1'b1;
            data_valid_q <= 1'b0;
            tx_data_q    <= 32'd0;
            tx_charisk_q <= 4'd0;
            link_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            txcominit_q  <= txcominit_d;
            txcomwake_q  <= txcomwake_d;
            txelecidle_q <= txelecidle_d;
            data_valid_q <= data_valid_d;
            tx_data_q    <= tx_data_d;
            tx_charisk_q <= tx_charisk_d;
            link_up_q    <= link_up_d;
        end
    end

    assign txcominit  = txcominit_q;
    assign txcomwake  = txcomwake_q;
    assign txelecidle = txelecidle_q;
    assign data_valid = data_valid_q;
    assign tx_data    = tx_data_q;
    assign tx_charisk = tx_charisk_q;
    assign link_up    = link_up_q;
    assign oob_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_gtx_oob_ctrl.sv
// ============================================================================
// Module   : tb_gtx_oob_ctrl
// Purpose  : Directed self-checking bench for gtx_oob_ctrl (short timeouts).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gtx_oob_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_reset_done, rx_reset_done;
    logic        txcomfinish, rxcominitdet, rxcomwakedet, rxelecidle;
    logic [31:0] rx_data;
    logic [3:0]  rx_charisk;
    logic        txcominit, txcomwake, txelecidle, data_valid, link_up;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk;
    logic [2:0]  oob_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gtx_oob_ctrl #(
        .COMINIT_TIMEOUT (32'd100),
        .ALIGN_TIMEOUT   (32'd64)
`ifdef LINK_LOSS_RECOVER_EN
        ,
        .IDLE_LOSS_CYCLES(16'd16)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_reset_done (tx_reset_done),
        .rx_reset_done (rx_reset_done),
        .txcomfinish   (txcomfinish),
        .rxcominitdet  (rxcominitdet),
        .rxcomwakedet  (rxcomwakedet),
        .rxelecidle    (rxelecidle),
        .rx_data       (rx_data),
        .rx_charisk    (rx_charisk),
        .txcominit     (txcominit),
        .txcomwake     (txcomwake),
        .txelecidle    (txelecidle),
        .data_valid    (data_valid),
        .tx_data       (tx_data),
        .tx_charisk    (tx_charisk),
        .link_up       (link_up),
        .oob_state     (oob_state)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_reset_done = 1'b0; rx_reset_done = 1'b0;
        txcomfinish = 1'b0; rxcominitdet = 1'b0; rxcomwakedet = 1'b0;
        rxelecidle = 1'b0; rx_data = 32'd0; rx_charisk = 4'd0;
        tick(3);
        rst = 1'b0;
    endtask

    // Reset, then walk the handshake up to WAIT_ALIGN (state 5).
    task automatic to_wait_align();
        do_reset();
        tx_reset_done = 1'b1; rx_reset_done = 1'b1;
        tick();
        txcomfinish = 1'b1;  tick(); txcomfinish = 1'b0;
        rxcominitdet = 1'b1; tick(); rxcominitdet = 1'b0;
        txcomfinish = 1'b1;  tick(); txcomfinish = 1'b0;
        rxcomwakedet = 1'b1; tick(); rxcomwakedet = 1'b0;
    endtask

    task automatic to_link_up();
        to_wait_align();
        rx_data = 32'h7B4A4ABC; rx_charisk = 4'b0001; tick();
        rx_data = 32'hB5B5957C; rx_charisk = 4'b0001; tick();
        rx_data = 32'd0; rx_charisk = 4'd0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        checks++;
        if ({txcominit, txcomwake, txelecidle, data_valid, link_up} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00100",
                     {txcominit, txcomwake, txelecidle, data_valid, link_up});
        end
        checks++;
        if ({tx_data, tx_charisk} !== 36'd0) begin
            errors++;
            $display("FAIL reset_txdata: got %h/%b required 0/0", tx_data, tx_charisk);
        end
        checks++;
        if (oob_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d required 0", oob_state);
        end
        rst = 1'b0;
        tick(4);
        checks++;
        if (oob_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_wait_hold: got %0d required 0", oob_state);
        end
    endtask

    task automatic test_bringup();
        do_reset();
        tx_reset_done = 1'b1; rx_reset_done = 1'b1;
        tick();
        checks++;
        if (oob_state !== 3'd1 || txcominit !== 1'b1) begin
            errors++;
            $display("FAIL cominit_entry: got state %0d txcominit %b required 1/1", oob_state, txcominit);
        end
        tick();
        checks++;
        if (oob_state !== 3'd1 || txcominit !== 1'b0) begin
            errors++;
            $display("FAIL cominit_pulse: got state %0d txcominit %b required 1/0", oob_state, txcominit);
        end
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        checks++;
        if (oob_state !== 3'd2) begin
            errors++;
            $display("FAIL wait_cominit: got %0d required 2", oob_state);
        end
        rxcominitdet = 1'b1; tick(); rxcominitdet = 1'b0;
        checks++;
        if (oob_state !== 3'd3 || txcomwake !== 1'b1) begin
            errors++;
            $display("FAIL comwake_entry: got state %0d txcomwake %b required 3/1", oob_state, txcomwake);
        end
        tick();
        checks++;
        if (txcomwake !== 1'b0) begin
            errors++;
            $display("FAIL comwake_pulse: got %b required 0", txcomwake);
        end
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        // Device re-issues COMINIT while we wait for COMWAKE.
        rxcominitdet = 1'b1; tick(); rxcominitdet = 1'b0;
        checks++;
        if (oob_state !== 3'd3 || txcomwake !== 1'b1) begin
            errors++;
            $display("FAIL comwake_retry: got state %0d txcomwake %b required 3/1", oob_state, txcomwake);
        end
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        checks++;
        if (oob_state !== 3'd4 || txelecidle !== 1'b1) begin
            errors++;
            $display("FAIL wait_comwake: got state %0d txelecidle %b required 4/1", oob_state, txelecidle);
        end
        rxcomwakedet = 1'b1; tick(); rxcomwakedet = 1'b0;
        checks++;
        if ({oob_state, txelecidle, data_valid, tx_data, tx_charisk} !== {3'd5, 1'b0, 1'b1, 32'h4A4A4A4A, 4'b0000}) begin
            errors++;
            $display("FAIL wait_align: got state %0d ei %b dv %b %h/%b required 5 0 1 4a4a4a4a/0000",
                     oob_state, txelecidle, data_valid, tx_data, tx_charisk);
        end
        rx_data = 32'h7B4A4ABC; rx_charisk = 4'b0001; tick();
        checks++;
        if ({oob_state, link_up, tx_data, tx_charisk} !== {3'd6, 1'b0, 32'h7B4A4ABC, 4'b0001}) begin
            errors++;
            $display("FAIL send_sync: got state %0d up %b %h/%b required 6 0 7b4a4abc/0001",
                     oob_state, link_up, tx_data, tx_charisk);
        end
        rx_data = 32'hB5B5957C; rx_charisk = 4'b0001; tick();
        rx_data = 32'd0; rx_charisk = 4'd0;
        checks++;
        if ({oob_state, link_up, data_valid, tx_data, tx_charisk} !== {3'd7, 1'b1, 1'b1, 32'hB5B5957C, 4'b0001}) begin
            errors++;
            $display("FAIL link_up: got state %0d up %b dv %b %h/%b required 7 1 1 b5b5957c/0001",
                     oob_state, link_up, data_valid, tx_data, tx_charisk);
        end
    endtask

    task automatic test_cominit_timeout();
        do_reset();
        tx_reset_done = 1'b1; rx_reset_done = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
            tick(99);
            checks++;
            if (oob_state !== 3'd2) begin
                errors++;
                $display("FAIL cominit_to_hold[%0d]: got %0d required 2", r, oob_state);
            end
            tick();
            checks++;
            if (oob_state !== 3'd1 || txcominit !== 1'b1) begin
                errors++;
                $display("FAIL cominit_to_retry[%0d]: got state %0d txcominit %b required 1/1",
                         r, oob_state, txcominit);
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        tx_reset_done = 1'b1; rx_reset_done = 1'b1;
        tick(2);
        txcomfinish = 1'b1; rxcominitdet = 1'b1; tick();
        txcomfinish = 1'b0; rxcominitdet = 1'b0;
        tick(5);
        checks++;
        if (oob_state !== 3'd2) begin
            errors++;
            $display("FAIL collision: got %0d required 2", oob_state);
        end
    endtask

    task automatic test_align_timeout();
        to_wait_align();
        rx_data = 32'h4A4A4A4A; rx_charisk = 4'b0000;
        tick(63);
        checks++;
        if (oob_state !== 3'd5 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL align_to_hold: got state %0d dv %b required 5/1", oob_state, data_valid);
        end
        tick();
        checks++;
        if ({oob_state, txelecidle, data_valid, txcominit} !== {3'd1, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL align_to_retry: got state %0d ei %b dv %b cominit %b required 1 1 0 1",
                     oob_state, txelecidle, data_valid, txcominit);
        end
        rx_data = 32'd0;
    endtask

    task automatic test_reset_done_loss();
        to_link_up();
        rx_reset_done = 1'b0; tick();
        checks++;
        if ({oob_state, link_up, txelecidle, data_valid, tx_data} !== {3'd0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL rdone_loss: got state %0d up %b ei %b dv %b %h required 0 0 1 0 0",
                     oob_state, link_up, txelecidle, data_valid, tx_data);
        end
        rx_reset_done = 1'b1;
    endtask

    task automatic test_idle_loss();
        to_link_up();
        rxelecidle = 1'b1;
`ifdef LINK_LOSS_RECOVER_EN
        tick(15);
        rxelecidle = 1'b0;
        checks++;
        if (oob_state !== 3'd7 || link_up !== 1'b1) begin
            errors++;
            $display("FAIL idle15_hold: got state %0d up %b required 7/1", oob_state, link_up);
        end
        tick();
        rxelecidle = 1'b1;
        tick(15);
        checks++;
        if (oob_state !== 3'd7) begin
            errors++;
            $display("FAIL idle_clear: got %0d required 7", oob_state);
        end
        tick();
        checks++;
        if ({oob_state, link_up, txelecidle, data_valid} !== {3'd1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL idle16_loss: got state %0d up %b ei %b dv %b required 1 0 1 0",
                     oob_state, link_up, txelecidle, data_valid);
        end
`else
        tick(40);
        checks++;
        if (oob_state !== 3'd7 || link_up !== 1'b1) begin
            errors++;
            $display("FAIL idle_ignored: got state %0d up %b required 7/1", oob_state, link_up);
        end
`endif
        rxelecidle = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_cominit_timeout();
        test_collision();
        test_align_timeout();
        test_reset_done_loss();
        test_idle_loss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
